hazard_control_unit: RTL

- Pipeline sequencing controller for the 6-stage core (IF, DE, EX, M1, M2, WB).
- Decides every cycle which stages hold, which receive a bubble, and when IF is flushed.
- Covers load-use hazards the forwarding network cannot resolve, data-memory wait states, multi-cycle mul/div in EX, instruction-memory wait and taken-branch redirect.
- Drives the `stalled` input of the forwarding unit and the enable/flush pins of all pipeline registers.

---
 rtl/hazard_control_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hold/bubble/flush sequencing for the 6-stage core
`ifndef MEM_NONE
`define MEM_NONE 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif

module hazard_control_unit #(
  parameter int PERF_W         = 32,
  parameter int MULDIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        decoded_rs1,
  input  logic [4:0]        decoded_rs2,
  input  logic [1:0]        de_dependency_check,
  input  logic              de_is_branch,
  input  logic              de_branch_taken,
  input  logic [4:0]        ex_rd,
  input  logic [2:0]        ex_wb_src,
  input  logic [4:0]        ex_mem_op,
  input  logic              ex_is_muldiv,
  input  logic              muldiv_done,
  input  logic [4:0]        m1_rd,
  input  logic [2:0]        m1_wb_src,
  input  logic [4:0]        m1_mem_op,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              stall_if,
  output logic              stall_de,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              bubble_ex,
  output logic              bubble_m1,
  output logic              flush_de,
  output logic              stalled,
  output logic              muldiv_start,
  output logic              muldiv_abort,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] load_use_events
);

  localparam int CNT_W = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_DMEM_WAIT, S_MULDIV} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] md_cnt;
  logic             rst_d, lu_prev;
  logic             lu_now, cnt_clr, cnt_inc, run_eval;
  logic             haz1, haz2, ex_load, m1_load, load_use, dmem_wait, muldiv_req;

  wire unused_fields = ^{ex_wb_src[1:0], ex_mem_op[2:0], m1_wb_src[1:0], m1_mem_op[2:0]};

  assign haz1    = de_dependency_check[0] | de_is_branch;
  assign haz2    = de_dependency_check[1] | de_is_branch;
  assign ex_load = ex_wb_src[2] && (ex_mem_op[4:3] == `MEM_READ) && (ex_rd != 5'd0);
  assign m1_load = m1_wb_src[2] && (m1_mem_op[4:3] == `MEM_READ) && (m1_rd != 5'd0);

  // A branch resolves in DE, so it must also wait out a load that has only reached M1.
  assign load_use = (ex_load && ((haz1 && ex_rd == decoded_rs1) || (haz2 && ex_rd == decoded_rs2)))
                 || (de_is_branch && m1_load && (m1_rd == decoded_rs1 || m1_rd == decoded_rs2));
  assign dmem_wait  = (m1_mem_op[4:3] != `MEM_NONE) && !dmem_ready;
  assign muldiv_req = ex_is_muldiv && !muldiv_done;

  always_comb begin
    next_state   = state;
    stall_if     = 1'b0;
    stall_de     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    bubble_ex    = 1'b0;
    bubble_m1    = 1'b0;
    flush_de     = 1'b0;
    muldiv_start = 1'b0;
    muldiv_abort = 1'b0;
    lu_now       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    run_eval     = 1'b0;

    // Outputs stay quiet while reset is held and for the cycle after it.
    if (rst || rst_d) begin
      next_state = S_RUN;
    end else begin
      case (state)
        S_MULDIV: begin
          if (muldiv_done) begin
            run_eval = 1'b1;
          end else if (md_cnt == CNT_LAST) begin
            muldiv_abort = 1'b1;
            next_state   = S_RUN;
          end else begin
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            stall_ex  = 1'b1;
            bubble_m1 = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        S_DMEM_WAIT: begin
          if (dmem_ready) begin
            run_eval = 1'b1;
          end else begin
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
          end
        end
        default: run_eval = 1'b1;
      endcase

      // Exit cycles from the wait states advance the pipeline, so they share the run decode.
      if (run_eval) begin
        next_state = S_RUN;
        if (dmem_wait) begin
          stall_if   = 1'b1;
          stall_de   = 1'b1;
          stall_ex   = 1'b1;
          stall_mem  = 1'b1;
          next_state = S_DMEM_WAIT;
        end else if (muldiv_req) begin
          muldiv_start = 1'b1;
          stall_if     = 1'b1;
          stall_de     = 1'b1;
          stall_ex     = 1'b1;
          bubble_m1    = 1'b1;
          cnt_clr      = 1'b1;
          next_state   = S_MULDIV;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_de  = 1'b1;
          bubble_ex = 1'b1;
          lu_now    = 1'b1;
        end else if (!imem_ready) begin
          stall_if = 1'b1;
          flush_de = 1'b1;
        end else if (de_branch_taken) begin
          flush_de = 1'b1;
        end
      end
    end
  end

  assign stalled = stall_de;

  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      state           <= S_RUN;
      md_cnt          <= '0;
      lu_prev         <= 1'b0;
      stall_cycles    <= '0;
      load_use_events <= '0;
    end else begin
      state   <= next_state;
      lu_prev <= lu_now;
      if (cnt_clr)
        md_cnt <= '0;
      else if (cnt_inc)
        md_cnt <= md_cnt + 1'b1;
      if (stall_de)
        stall_cycles <= stall_cycles + 1'b1;
      if (lu_now && !lu_prev)
        load_use_events <= load_use_events + 1'b1;
    end
  end

endmodule
